mips_cpu_bus_lsu: RTL

//  Load/store unit between the CPU datapath and the Avalon-style memory bus (directly upstream of bus memory).

---
 rtl/mips_cpu_bus_lsu.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_cpu_bus_lsu.sv
// Load/store unit between the CPU datapath and an Avalon-style memory bus, one request in flight.
// Latency: store resp_valid 2 cycles after handshake (+ waitrequest stalls); load 2+READ_LATENCY (+ stalls).
// Backpressure: req_ready only in IDLE; bus command held while waitrequest=1; response held until resp_ready.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   req_valid/req_ready         request handshake; req_we, req_op, req_addr, req_wdata captured on handshake
//   resp_valid/resp_ready       response handshake; resp_rdata (extended load data), resp_err
//   address, read, write        word-aligned bus address and command strobes (never both high)
//   byteenable, writedata       active lanes and lane-placed store data
//   waitrequest, readdata       slave stall and read data (READ_LATENCY cycles after read acceptance)
//
// Parameters: ADDR_W (bus address width), READ_LATENCY (1..4).
// Optional feature macro: MIPS_LSU_ALIGN_CHECK_EN -- when defined, misaligned H/HU/W requests are
// reported as errors without a bus cycle; when undefined, low address bits below the access size are ignored.

module mips_cpu_bus_lsu #(
   parameter int ADDR_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] address,
   output logic              read,
   output logic              write,
   output logic [3:0]        byteenable,
   output logic [31:0]       writedata,
   input  logic              waitrequest,
   input  logic [31:0]       readdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t state, state_nxt;

   // captured request
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wd_q;
   logic [2:0]        op_q;
   logic              we_q;
   logic [1:0]        lo_q;
   logic [1:0]        cnt_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   // request decode
   logic              accept;
   logic              op_legal;
   logic              misalign;
   logic              req_bad;
   logic [3:0]        be_nxt;
   logic [31:0]       wd_nxt;
   logic [31:0]       load_ext;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;

   assign accept = req_valid & req_ready;

   always_comb begin
      op_legal = 1'b0;
      case (req_op)
         3'b000, 3'b001, 3'b011: op_legal = 1'b1;
         // unsigned variants only make sense for loads
         3'b100, 3'b101:         op_legal = ~req_we;
         default:                op_legal = 1'b0;
      endcase
   end

`ifdef MIPS_LSU_ALIGN_CHECK_EN
   always_comb begin
      misalign = 1'b0;
      case (req_op[1:0])
         2'b01:   misalign = req_addr[0];
         2'b11:   misalign = (req_addr[1:0] != 2'b00);
         default: misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   assign req_bad = ~op_legal | misalign;

   always_comb begin
      be_nxt = 4'b1111;
      wd_nxt = req_wdata;
      case (req_op[1:0])
         2'b00: begin
            be_nxt = 4'b0001 << req_addr[1:0];
            wd_nxt = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_nxt = req_addr[1] ? 4'b1100 : 4'b0011;
            wd_nxt = {2{req_wdata[15:0]}};
         end
         default: begin
            be_nxt = 4'b1111;
            wd_nxt = req_wdata;
         end
      endcase
   end

   // Lane selection: halfword uses only addr[1], so an odd halfword address
   // (allowed when the alignment check is off) still lands on a legal lane.
   assign lane_b = readdata[{lo_q, 3'b000} +: 8];
   assign lane_h = readdata[{lo_q[1], 4'b0000} +: 16];

   always_comb begin
      load_ext = readdata;
      case (op_q)
         3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
         3'b100:  load_ext = {24'd0, lane_b};
         3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
         3'b101:  load_ext = {16'd0, lane_h};
         default: load_ext = readdata;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = req_bad ? S_RESP : S_CMD;
            end
         end
         S_CMD: begin
            if (!waitrequest) begin
               state_nxt = we_q ? S_RESP : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == 2'd0) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // outputs decoded from registered state only; reset is folded into
   // req_ready so the unit never advertises readiness during reset
   always_comb begin
      req_ready  = (state == S_IDLE) & ~reset;
      resp_valid = (state == S_RESP);
      read       = (state == S_CMD) & ~we_q;
      write      = (state == S_CMD) &  we_q;
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         be_q    <= '0;
         wd_q    <= '0;
         op_q    <= '0;
         we_q    <= 1'b0;
         lo_q    <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q    <= req_op;
                  we_q    <= req_we;
                  lo_q    <= req_addr[1:0];
                  err_q   <= req_bad;
                  rdata_q <= '0;
                  // rejected requests leave the bus-facing registers untouched
                  if (!req_bad) begin
                     addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                     be_q   <= be_nxt;
                     wd_q   <= wd_nxt;
                  end
               end
            end
            S_CMD: begin
               if (!waitrequest) begin
                  cnt_q <= 2'(READ_LATENCY - 1);
               end
            end
            S_DATA: begin
               if (cnt_q != 2'd0) begin
                  cnt_q <= cnt_q - 2'd1;
               end else begin
                  rdata_q <= load_ext;
               end
            end
            S_RESP: begin
               // clear so rdata/err read as zero between responses
               if (resp_ready) begin
                  rdata_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign address    = addr_q;
   assign byteenable = be_q;
   assign writedata  = wd_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
